parameterized_register_file: RTL and testbench
==============================================

PARAMETERIZED_REGISTER_FILE -- requirements
Module: parameterized_register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of each register and of data and read outputs.
REQ-002 Parameter ADDR_WIDTH, default 5: address width; register count is 2^ADDR_WIDTH.
REQ-003 Parameter ZERO_REG_EN, default 1: when 1, the highest address (all ones, X31/XZR) SHALL read 0 and ignore writes.
REQ-004 Parameter BYPASS_EN, default 1: when 1, a same-cycle write SHALL be forwarded to matching read ports.
REQ-005 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 read_reg_address_1  input  ADDR_WIDTH  read port 1 address.
REQ-008 read_reg_address_2  input  ADDR_WIDTH  read port 2 address.
REQ-009 write_reg_address  input  ADDR_WIDTH  write address.
REQ-010 data  input  DATA_WIDTH  write data.
REQ-011 reg_write  input  1  write enable.
REQ-012 clear_req  input  1  request a full sequential clear of the array.
REQ-013 reg_out_1  output  DATA_WIDTH  read port 1 data, combinational.
REQ-014 reg_out_2  output  DATA_WIDTH  read port 2 data, combinational.
REQ-015 clear_busy  output  1  high while a clear is in progress.
REQ-016 clear_done  output  1  one-cycle pulse when a clear completes.
REQ-017 write_rejected  output  1  combinational: reg_write & clear_busy.

Function
REQ-018 FSM states: IDLE, CLEAR; a clear counter of ADDR_WIDTH bits holds the next address to clear.
REQ-019 IDLE: a rising edge with reg_write=1 SHALL store data at write_reg_address (except the zero register when ZERO_REG_EN=1).
REQ-020 IDLE with clear_req=1 at an edge: go to CLEAR with counter=0; a write at that same edge SHALL still execute.
REQ-021 CLEAR: each edge SHALL write 0 at the counter address and increment the counter; after writing address 2^ADDR_WIDTH-1, go to IDLE.
REQ-022 A clear SHALL take exactly 2^ADDR_WIDTH edges; clear_busy SHALL be high for exactly those cycles.
REQ-023 clear_done SHALL be high for exactly the one cycle after the CLEAR->IDLE edge, and 0 otherwise.
REQ-024 In CLEAR, reg_write SHALL be ignored (array unchanged by it) and write_rejected SHALL be 1.
REQ-025 clear_req in CLEAR SHALL be ignored; the clear SHALL NOT restart or extend.
REQ-026 While clear_busy=1, reg_out_1 and reg_out_2 SHALL be 0.
REQ-027 In IDLE, reg_out_n SHALL equal the stored value at read_reg_address_n; the zero register reads 0 when ZERO_REG_EN=1.
REQ-028 Bypass (BYPASS_EN=1, IDLE): if reg_write=1 and write_reg_address==read_reg_address_n and the address is not the zero register, reg_out_n SHALL equal data in the same cycle; with BYPASS_EN=0, the stored value is read until the edge.
REQ-029 Both read ports SHALL be independent and may address the same register.

Reset
REQ-030 Asserting reset SHALL immediately force state=CLEAR, counter=0, clear_busy=1, clear_done=0, reg_out_1=reg_out_2=0.
REQ-031 The array SHALL NOT be reset asynchronously; after reset deasserts it SHALL be zeroed by the CLEAR sequence of REQ-021.
REQ-032 Reset asserted mid-clear SHALL restart the clear from counter=0 with no clear_done pulse for the aborted clear.

Structure
REQ-033 Package regfile_pkg SHALL hold the FSM state type and the default DATA_WIDTH/ADDR_WIDTH constants.
REQ-034 The FSM and counter SHALL be a sub-module named clear_sequencer, outputting clear address, clear write enable, clear_busy and clear_done.

Verification (DATA_WIDTH=64, ADDR_WIDTH=5, both enables=1)
REQ-035 Reset pulse, then hold: clear_busy=1 for 32 edges, clear_done pulse 1 cycle, then all 32 registers read 0.
REQ-036 IDLE: write 43 to address 9, then write 3 to address 16; read ports 1/2 at 9/16 -> 43/3; meanwhile address 4 reads 0.
REQ-037 Write 0xDEAD to address 31 -> address 31 reads 0; bypass to port 1 at address 12 while writing 7 there -> reg_out_1=7 before the edge.
REQ-038 clear_req with a write of 5 to address 2 in the same cycle -> clear runs 32 cycles, write_rejected=1 for a write attempt during them, address 2 reads 0 after clear_done.
REQ-039 clear_req re-pulsed at cycle 10 of a clear -> clear_done still exactly 32 cycles after the start; reset at cycle 20 -> no clear_done, new 32-cycle clear.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the register file and its clear sequencer.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 64;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_CLEAR = 1'b1;

endpackage

// File: rtl/clear_sequencer.sv
// Walks a counter over every array address, issuing zero writes, on reset or clear request.
module clear_sequencer
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic [ADDR_WIDTH-1:0] clear_addr,
  output logic                  clear_we_c,
  output logic                  clear_busy,
  output logic                  clear_done
);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] count_next;
  logic                  done_next;

  // Reset lands in CLEAR so the uninitialised array is zeroed after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_CLEAR;
      count      <= '0;
      clear_busy <= 1'b1;
      clear_done <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      clear_busy <= (state_next == ST_CLEAR);
      clear_done <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_next = ST_CLEAR;
          count_next = '0;
        end
      end
      ST_CLEAR: begin
        // clear_req is deliberately ignored here so a clear never restarts.
        count_next = count + ADDR_WIDTH'(1);
        if (count == '1) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = ST_CLEAR;
        count_next = '0;
      end
    endcase
  end

  assign clear_addr = count;
  assign clear_we_c = (state == ST_CLEAR);

endmodule

// File: rtl/parameterized_register_file.sv
// Two-read, one-write register file with optional zero register, write bypass and sequential clear.
module parameterized_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter bit          ZERO_REG_EN = 1'b1,
  parameter bit          BYPASS_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg_address_1,
  input  logic [ADDR_WIDTH-1:0] read_reg_address_2,
  input  logic [ADDR_WIDTH-1:0] write_reg_address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  reg_write,
  input  logic                  clear_req,
  output logic [DATA_WIDTH-1:0] reg_out_1,
  output logic [DATA_WIDTH-1:0] reg_out_2,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  write_rejected
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] clear_addr;
  logic                  clear_we_c;
  logic                  wr_zero_c;
  logic                  wr_en_c;
  logic                  rd1_zero_c;
  logic                  rd2_zero_c;
  logic                  byp1_c;
  logic                  byp2_c;

  clear_sequencer #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_sequencer (
    .clk        (clk),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_addr (clear_addr),
    .clear_we_c (clear_we_c),
    .clear_busy (clear_busy),
    .clear_done (clear_done)
  );

  assign write_rejected = reg_write & clear_busy;

  assign wr_zero_c = ZERO_REG_EN && (write_reg_address == '1);
  assign wr_en_c   = reg_write && !clear_busy && !wr_zero_c;

  // The array has no reset; the sequencer zeroes it after reset release.
  always_ff @(posedge clk) begin
    if (clear_we_c) begin
      mem[clear_addr] <= '0;
    end else if (wr_en_c) begin
      mem[write_reg_address] <= data;
    end
  end

  assign rd1_zero_c = ZERO_REG_EN && (read_reg_address_1 == '1);
  assign rd2_zero_c = ZERO_REG_EN && (read_reg_address_2 == '1);
  assign byp1_c     = BYPASS_EN && wr_en_c && (write_reg_address == read_reg_address_1);
  assign byp2_c     = BYPASS_EN && wr_en_c && (write_reg_address == read_reg_address_2);

  always_comb begin
    reg_out_1 = mem[read_reg_address_1];
    if (clear_busy || rd1_zero_c) begin
      reg_out_1 = '0;
    end else if (byp1_c) begin
      reg_out_1 = data;
    end
  end

  always_comb begin
    reg_out_2 = mem[read_reg_address_2];
    if (clear_busy || rd2_zero_c) begin
      reg_out_2 = '0;
    end else if (byp2_c) begin
      reg_out_2 = data;
    end
  end

endmodule

// File: tb/tb_parameterized_register_file.sv
// Directed self-checking bench for parameterized_register_file at default parameters.
module tb_parameterized_register_file;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          reset;
  logic [AW-1:0] read_reg_address_1;
  logic [AW-1:0] read_reg_address_2;
  logic [AW-1:0] write_reg_address;
  logic [DW-1:0] data;
  logic          reg_write;
  logic          clear_req;
  logic [DW-1:0] reg_out_1;
  logic [DW-1:0] reg_out_2;
  logic          clear_busy;
  logic          clear_done;
  logic          write_rejected;

  int n_cmp = 0;
  int n_err = 0;

  parameterized_register_file #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .ZERO_REG_EN (1'b1),
    .BYPASS_EN   (1'b1)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .read_reg_address_1 (read_reg_address_1),
    .read_reg_address_2 (read_reg_address_2),
    .write_reg_address  (write_reg_address),
    .data               (data),
    .reg_write          (reg_write),
    .clear_req          (clear_req),
    .reg_out_1          (reg_out_1),
    .reg_out_2          (reg_out_2),
    .clear_busy         (clear_busy),
    .clear_done         (clear_done),
    .write_rejected     (write_rejected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_cmp++;
    if (clear_busy !== 1'b1 || clear_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: busy=%b done=%b expected busy=1 done=0", clear_busy, clear_done);
    end
    n_cmp++;
    if (reg_out_1 !== '0 || reg_out_2 !== '0) begin
      n_err++;
      $display("FAIL reset_outs: out1=%h out2=%h expected 0", reg_out_1, reg_out_2);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (clear_busy !== 1'b1 || clear_done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_clear_cycle%0d: busy=%b done=%b expected busy=1 done=0", i, clear_busy, clear_done);
      end
      tick();
    end
    n_cmp++;
    if (clear_busy !== 1'b0 || clear_done !== 1'b1) begin
      n_err++;
      $display("FAIL reset_clear_end: busy=%b done=%b expected busy=0 done=1", clear_busy, clear_done);
    end
    tick();
    n_cmp++;
    if (clear_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done_width: done=%b expected 0", clear_done);
    end
    for (int a = 0; a < 32; a++) begin
      read_reg_address_1 = AW'(a);
      read_reg_address_2 = AW'(31 - a);
      #1;
      n_cmp++;
      if (reg_out_1 !== '0 || reg_out_2 !== '0) begin
        n_err++;
        $display("FAIL reset_zeroed_a%0d: out1=%h out2=%h expected 0", a, reg_out_1, reg_out_2);
      end
    end
  endtask

  task automatic test_write_read();
    write_reg_address = 5'd9;
    data              = 64'd43;
    reg_write         = 1'b1;
    #1;
    n_cmp++;
    if (write_rejected !== 1'b0) begin
      n_err++;
      $display("FAIL idle_not_rejected: rej=%b expected 0", write_rejected);
    end
    tick();
    write_reg_address = 5'd16;
    data              = 64'd3;
    tick();
    reg_write          = 1'b0;
    read_reg_address_1 = 5'd9;
    read_reg_address_2 = 5'd16;
    #1;
    n_cmp++;
    if (reg_out_1 !== 64'd43 || reg_out_2 !== 64'd3) begin
      n_err++;
      $display("FAIL read_9_16: out1=%0d out2=%0d expected 43/3", reg_out_1, reg_out_2);
    end
    read_reg_address_1 = 5'd4;
    read_reg_address_2 = 5'd9;
    #1;
    n_cmp++;
    if (reg_out_1 !== 64'd0 || reg_out_2 !== 64'd43) begin
      n_err++;
      $display("FAIL read_4_9: out1=%0d out2=%0d expected 0/43", reg_out_1, reg_out_2);
    end
  endtask

  task automatic test_zero_and_bypass();
    write_reg_address  = 5'd31;
    data               = 64'hDEAD;
    reg_write          = 1'b1;
    read_reg_address_1 = 5'd31;
    #1;
    n_cmp++;
    if (reg_out_1 !== '0) begin
      n_err++;
      $display("FAIL zero_reg_no_bypass: out1=%h expected 0", reg_out_1);
    end
    tick();
    reg_write = 1'b0;
    #1;
    n_cmp++;
    if (reg_out_1 !== '0) begin
      n_err++;
      $display("FAIL zero_reg_read: out1=%h expected 0", reg_out_1);
    end
    read_reg_address_1 = 5'd12;
    read_reg_address_2 = 5'd12;
    write_reg_address  = 5'd12;
    data               = 64'd7;
    reg_write          = 1'b1;
    #1;
    n_cmp++;
    if (reg_out_1 !== 64'd7 || reg_out_2 !== 64'd7) begin
      n_err++;
      $display("FAIL bypass_12: out1=%0d out2=%0d expected 7/7", reg_out_1, reg_out_2);
    end
    tick();
    reg_write = 1'b0;
    data      = 64'd99;
    #1;
    n_cmp++;
    if (reg_out_1 !== 64'd7) begin
      n_err++;
      $display("FAIL stored_12: out1=%0d expected 7", reg_out_1);
    end
  endtask

  task automatic test_clear_req();
    write_reg_address = 5'd2;
    data              = 64'd5;
    reg_write         = 1'b1;
    clear_req         = 1'b1;
    tick();
    clear_req = 1'b0;
    reg_write = 1'b0;
    read_reg_address_1 = 5'd9;
    read_reg_address_2 = 5'd16;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin
        write_reg_address = 5'd9;
        data              = 64'h99;
        reg_write         = 1'b1;
        #1;
        n_cmp++;
        if (write_rejected !== 1'b1) begin
          n_err++;
          $display("FAIL clear_rejected: rej=%b expected 1", write_rejected);
        end
      end
      n_cmp++;
      if (clear_busy !== 1'b1 || reg_out_1 !== '0 || reg_out_2 !== '0) begin
        n_err++;
        $display("FAIL clear_cycle%0d: busy=%b out1=%h out2=%h expected busy=1 outs=0",
                 i, clear_busy, reg_out_1, reg_out_2);
      end
      tick();
    end
    reg_write = 1'b0;
    n_cmp++;
    if (clear_busy !== 1'b0 || clear_done !== 1'b1) begin
      n_err++;
      $display("FAIL clear_end: busy=%b done=%b expected busy=0 done=1", clear_busy, clear_done);
    end
    read_reg_address_1 = 5'd2;
    read_reg_address_2 = 5'd9;
    #1;
    n_cmp++;
    if (reg_out_1 !== '0 || reg_out_2 !== '0) begin
      n_err++;
      $display("FAIL after_clear: out1=%h out2=%h expected 0/0", reg_out_1, reg_out_2);
    end
  endtask

  task automatic test_restart();
    int k;
    bit early;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    k = 0;
    while (k < 40) begin
      clear_req = (k == 9);
      tick();
      k++;
      if (clear_done === 1'b1) break;
    end
    clear_req = 1'b0;
    n_cmp++;
    if (k !== 32) begin
      n_err++;
      $display("FAIL repulse_done_cycle: got=%0d expected 32", k);
    end
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (clear_done === 1'b1) early = 1'b1;
    end
    reset = 1'b1;
    #2;
    n_cmp++;
    if (clear_busy !== 1'b1 || clear_done !== 1'b0 || early !== 1'b0) begin
      n_err++;
      $display("FAIL midclear_reset: busy=%b done=%b early=%b expected 1/0/0", clear_busy, clear_done, early);
    end
    reset = 1'b0;
    k = 0;
    while (k < 50) begin
      tick();
      k++;
      if (clear_done === 1'b1) break;
    end
    n_cmp++;
    if (k !== 32) begin
      n_err++;
      $display("FAIL reset_restart_done_cycle: got=%0d expected 32", k);
    end
  endtask

  initial begin
    reset              = 1'b0;
    read_reg_address_1 = '0;
    read_reg_address_2 = '0;
    write_reg_address  = '0;
    data               = '0;
    reg_write          = 1'b0;
    clear_req          = 1'b0;
    #3;
    test_reset();
    test_write_read();
    test_zero_and_bypass();
    test_clear_req();
    test_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
